// File: rtl/expr_seq_pkg.sv
// Shared state encoding, widths and polynomial constants for the
// expression stimulus sequencer and its MISR.
package expr_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_CAPTURE,
    ST_DONE
  } seqState_e;

  localparam int OPND_W = 60;
  localparam int Y_W    = 90;
  localparam int SIG_W  = 32;

  localparam logic [SIG_W-1:0] MISR_POLY = 32'h04C1_1DB7;
  localparam logic [SIG_W-1:0] MISR_INIT = 32'hFFFF_FFFF;

  localparam int LFSR_TAP_A = 63;
  localparam int LFSR_TAP_B = 62;
  localparam int LFSR_TAP_C = 60;
  localparam int LFSR_TAP_D = 59;

  // One Fibonacci step: shift toward the MSB, XOR of the taps enters bit 0.
  function automatic logic [63:0] lfsrStep(input logic [63:0] s);
    return {s[62:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D]};
  endfunction

endpackage

// File: rtl/expr_seq_misr.sv
// 32-bit MISR compacting the 90-bit result bus; clear reloads the
// all-ones init value and takes precedence over enable.
module expr_seq_misr
  import expr_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [Y_W-1:0]   y_in,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;
  logic [SIG_W-1:0] fold;

  always_comb begin
    fold  = y_in[31:0] ^ y_in[63:32] ^ {6'b0, y_in[89:64]};
    sig_d = sig_q;
    if (clear) begin
      sig_d = MISR_INIT;
    end else if (enable) begin
      sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_POLY : '0) ^ fold;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= MISR_INIT;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/expr_stim_sequencer.sv
// Drives LFSR operands into an expression datapath and folds its results
// into a MISR signature. Define EXPR_SEQ_GOLDEN_EN for the pass/fail compare.
module expr_stim_sequencer
  import expr_seq_pkg::*;
#(
  parameter logic [63:0] SEED  = 64'hACE1_0000_0000_0001,
  parameter int          LAT   = 1,
  parameter int          CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_vec,
  output logic [OPND_W-1:0] opnd,
  input  logic [Y_W-1:0]    y_in,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  vec_idx,
  output logic [SIG_W-1:0]  signature
`ifdef EXPR_SEQ_GOLDEN_EN
  ,
  input  logic [SIG_W-1:0]  exp_sig,
  output logic              pass,
  output logic              fail
`endif
);

  localparam logic [3:0]       LAT_M1 = (LAT > 0) ? 4'(LAT - 1) : 4'd0;
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  seqState_e         state_q, state_d;
  logic [CNT_W-1:0]  numVec_q, numVec_d;
  logic [CNT_W-1:0]  vecIdx_q, vecIdx_d;
  logic [63:0]       lfsr_q, lfsr_d;
  logic [OPND_W-1:0] opnd_q, opnd_d;
  logic [3:0]        waitCnt_q, waitCnt_d;
  logic [63:0]       lfsrNext;
  logic              accept;
  logic              capture;
  logic              lastVec;

  assign accept   = (state_q == ST_IDLE) && start;
  assign capture  = (state_q == ST_CAPTURE) && !abort;
  assign lastVec  = (vecIdx_q == numVec_q - ONE);
  assign lfsrNext = lfsrStep(lfsr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort wins over every transition, but only once a run is under way.
  always_comb begin
    state_d = state_q;
    if ((state_q != ST_IDLE) && abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (start) state_d = (num_vec == '0) ? ST_DONE : ST_DRIVE;
        ST_DRIVE:   state_d = (LAT > 0) ? ST_WAIT : ST_CAPTURE;
        ST_WAIT:    if (waitCnt_q == 4'd0) state_d = ST_CAPTURE;
        ST_CAPTURE: state_d = lastVec ? ST_DONE : ST_DRIVE;
        ST_DONE:    state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
`ifdef EXPR_SEQ_GOLDEN_EN
    pass = done && (signature == exp_sig);
    fail = done && (signature != exp_sig);
`endif
  end

  // Operands load on every entry into DRIVE so they are valid for the whole vector.
  always_comb begin
    numVec_d  = numVec_q;
    vecIdx_d  = vecIdx_q;
    lfsr_d    = lfsr_q;
    opnd_d    = opnd_q;
    waitCnt_d = waitCnt_q;
    if (accept) begin
      numVec_d = num_vec;
      vecIdx_d = '0;
      lfsr_d   = SEED;
      if (num_vec != '0) begin
        opnd_d = SEED[OPND_W-1:0];
      end
    end
    if (capture) begin
      lfsr_d = lfsrNext;
      if (!lastVec) begin
        vecIdx_d = vecIdx_q + ONE;
        opnd_d   = lfsrNext[OPND_W-1:0];
      end
    end
    if (state_q == ST_DRIVE) begin
      waitCnt_d = LAT_M1;
    end else if ((state_q == ST_WAIT) && (waitCnt_q != 4'd0)) begin
      waitCnt_d = waitCnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      numVec_q  <= '0;
      vecIdx_q  <= '0;
      lfsr_q    <= SEED;
      opnd_q    <= '0;
      waitCnt_q <= 4'd0;
    end else begin
      numVec_q  <= numVec_d;
      vecIdx_q  <= vecIdx_d;
      lfsr_q    <= lfsr_d;
      opnd_q    <= opnd_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  expr_seq_misr u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .enable (capture),
    .y_in   (y_in),
    .sig    (signature)
  );

  assign opnd    = opnd_q;
  assign vec_idx = vecIdx_q;

endmodule
